timer_counter: RTL and testbench
================================

Name: timer_counter

Overview:
- Memory-mapped timer/counter peripheral that sits on the CPU's peripheral bus behind the address bridge.
- It is the responder end of the CPU's load/store peripheral accesses: it accepts register writes, returns register reads, counts down, and raises an interrupt request to the CP0 interrupt input.
- Two instances are placed in the top-level system next to the `mips` core.

Parameters:
- WIDTH, 32, width of data bus, PRESET and COUNT registers.
- RESET_PRESET, 0, reset value of PRESET.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; all state cleared while low.
- addr  input  2  word select (bus address bits [3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
- we  input  1  write enable for the current bus cycle.
- wdata  input  WIDTH  write data.
- rdata  output  WIDTH  read data, combinational from addr.
- irq  output  1  interrupt request to CP0, level.

Behaviour:
Register map:
- CTRL[0] EN: counter enable.
- CTRL[2:1] MODE: 0 = one-shot, 1 = auto-reload, 2 and 3 behave as 0.
- CTRL[3] IM: interrupt mask, 1 = irq allowed.
- CTRL[WIDTH-1:4] read as 0.

Reads and writes:
- rdata = CTRL / PRESET / COUNT per addr; reserved address reads 0.
- Writes to COUNT or reserved are ignored.
- Writes take effect at the clock edge.

Reset (reset low, asynchronous):
- CTRL=0, PRESET=RESET_PRESET, COUNT=0, state IDLE, pending=0.
- Hence rdata reflects zeros and irq=0.

FSM:
- IDLE: when EN=1 -> LOAD.
- LOAD: COUNT<=PRESET -> CNT.
- CNT:
  - If EN=0 -> IDLE with COUNT frozen.
  - Else if COUNT>1: COUNT-1.
  - Else: COUNT<=0 -> INT.
- INT: pending<=1.
  - MODE 0: EN cleared -> IDLE.
  - MODE 1: -> LOAD.

Interrupt:
- irq = pending & IM.
- MODE 0: pending held until any CTRL write.
- MODE 1: pending cleared automatically one cycle after being set, so irq is a 1-cycle pulse.

Latency: with PRESET=N≥1, the INT state is entered N+1 edges after leaving IDLE (LOAD plus N-1 decrements plus the final edge); irq rises on the following edge.

Boundary conditions:
- PRESET=0: behaves like PRESET=1 (LOAD then immediate INT).
- PRESET write mid-count: no effect until the next LOAD.
- CTRL write in the same cycle as INT clearing EN: bus write wins, EN takes wdata[0].
- CTRL write in the same cycle pending would set: pending is set (the FSM event wins over the clear).
- Reset asserted mid-count: immediate return to reset values; no irq glitch.
- Counter never wraps below 0.

Decomposition:
- Shared package holds:
  - register offset constants (CTRL/PRESET/COUNT);
  - CTRL bit positions;
  - MODE encodings;
  - FSM state encoding (IDLE, LOAD, CNT, INT).
- No sub-module: register file, FSM and irq logic sit in one module.
- The bridge decodes the base address and drives addr/we.

Test Plan:
- Reset check: hold reset low 2 cycles -> reading CTRL, PRESET, COUNT returns 0; irq=0.
- One-shot: write PRESET=3, then CTRL=0b1001 (EN, MODE0, IM) -> COUNT reads 3,2,1,0 on successive cycles; irq goes 1 and stays 1; CTRL[0] reads 0; writing CTRL=0 drops irq the next cycle.
- Auto-reload: PRESET=2, CTRL=0b1011 -> irq pulses for exactly 1 cycle every 4 cycles (LOAD, 2→1, 1→0/INT, pending), repeating ≥3 times.
- Mask/disable: PRESET=5, CTRL=0b0001 (IM=0) -> no irq, CTRL[0]=0 after expiry. Separately, write CTRL=0 while COUNT=3 -> COUNT frozen at 3, no irq.
- Mid-operation: write PRESET=10 during a count from 4 -> current run still expires after 4; the next auto-reload loads 10. Assert reset with COUNT=2 -> all registers read 0 immediately, irq=0.
- Writes to COUNT (wdata=0xFFFF) and to the reserved address are ignored -> read values unchanged; reserved reads 0.

Source files
------------

// File: rtl/timer_counter_pkg.sv
// Shared definitions for the timer_counter peripheral: register offsets,
// CTRL bit positions, MODE encodings and FSM state encoding.
package timer_counter_pkg;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_PRESET = 2'd1,
        REG_COUNT  = 2'd2,
        REG_RSVD   = 2'd3
    } timer_reg_e;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM       = 3;
    localparam int CTRL_BITS     = 4;

    // Encodings 2 and 3 are treated as one-shot.
    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'd0,
        MODE_RELOAD  = 2'd1,
        MODE_RSVD2   = 2'd2,
        MODE_RSVD3   = 2'd3
    } timer_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_e;

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a
// maskable level interrupt towards CP0.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_PRESET = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             irq
);

    // Bus cycle: single cycle, no wait states; a write with we=1 commits at the
    // next rising edge, rdata always reflects the word selected by addr.
    logic [CTRL_BITS-1:0] ctrl_q, ctrl_d;
    logic [WIDTH-1:0]     preset_q, preset_d;
    logic [WIDTH-1:0]     count_q, count_d;
    logic                 pending_q, pending_d;
    timer_state_e         state_q, state_d;

    logic ctrl_wr;
    logic preset_wr;
    logic en;
    logic reload;

    assign ctrl_wr   = we && (timer_reg_e'(addr) == REG_CTRL);
    assign preset_wr = we && (timer_reg_e'(addr) == REG_PRESET);
    assign en        = ctrl_q[CTRL_EN];
    assign reload    = (timer_mode_e'(ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB]) == MODE_RELOAD);

    always_comb begin
        ctrl_d    = ctrl_q;
        preset_d  = preset_q;
        count_d   = count_q;
        pending_d = pending_q;
        state_d   = state_q;

        // Clears come first so that the INT event below overrides them.
        if (reload || ctrl_wr) begin
            pending_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (count_q > WIDTH'(1)) begin
                    count_d = count_q - WIDTH'(1);
                end else begin
                    count_d = '0;
                    state_d = ST_INT;
                end
            end
            ST_INT: begin
                pending_d = 1'b1;
                if (reload) begin
                    state_d = ST_LOAD;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                    state_d         = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Bus writes are applied last: a CTRL write beats the one-shot EN clear.
        if (ctrl_wr) begin
            ctrl_d = wdata[CTRL_BITS-1:0];
        end
        if (preset_wr) begin
            preset_d = wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q    <= '0;
            preset_q  <= RESET_PRESET;
            count_q   <= '0;
            pending_q <= 1'b0;
            state_q   <= ST_IDLE;
        end else begin
            ctrl_q    <= ctrl_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            state_q   <= state_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (timer_reg_e'(addr))
            REG_CTRL:   rdata[CTRL_BITS-1:0] = ctrl_q;
            REG_PRESET: rdata = preset_q;
            REG_COUNT:  rdata = count_q;
            default:    rdata = '0;
        endcase
    end

    assign irq = pending_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: directed register-map scenarios followed by random
// bus traffic, every cycle's rdata/irq checked against a behavioural model.
module tb_timer_counter;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic [1:0]   addr;
    logic         we;
    logic [W-1:0] wdata;
    logic [W-1:0] rdata;
    logic         irq;

    timer_counter #(.WIDTH(W), .RESET_PRESET('0)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        reset = 1'b0;
        we    = 1'b0;
        addr  = 2'd0;
        wdata = '0;
    end

    // ---------------- scoreboard ----------------
    logic [W:0] exp_q[$];
    logic [1:0] adr_q[$];
    int vectors     = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    // A run goes: armed (load next edge) -> counting -> expired (raise pending).
    logic [3:0]   m_ctrl;
    logic [W-1:0] m_preset;
    logic [W-1:0] m_count;
    logic         m_pend;
    bit           m_armed;
    bit           m_counting;
    bit           m_expired;

    function automatic void model_reset();
        m_ctrl     = 4'd0;
        m_preset   = '0;
        m_count    = '0;
        m_pend     = 1'b0;
        m_armed    = 1'b0;
        m_counting = 1'b0;
        m_expired  = 1'b0;
    endfunction

    function automatic void model_edge(input logic w, input logic [1:0] a, input logic [W-1:0] d);
        logic       en;
        logic       auto_reload;
        logic       ctrl_w;
        logic [3:0] n_ctrl;
        logic       n_pend;
        en          = m_ctrl[0];
        auto_reload = (m_ctrl[2:1] == 2'd1);
        ctrl_w      = w && (a == 2'd0);
        n_ctrl      = m_ctrl;
        n_pend      = (auto_reload || ctrl_w) ? 1'b0 : m_pend;
        if (m_expired) begin
            m_expired = 1'b0;
            n_pend    = 1'b1;
            if (auto_reload) m_armed = 1'b1;
            else n_ctrl[0] = 1'b0;
        end else if (m_armed) begin
            m_armed    = 1'b0;
            m_count    = m_preset;
            m_counting = 1'b1;
        end else if (m_counting) begin
            if (!en) begin
                m_counting = 1'b0;
            end else if (m_count > 1) begin
                m_count = m_count - 1;
            end else begin
                m_count    = '0;
                m_counting = 1'b0;
                m_expired  = 1'b1;
            end
        end else if (en) begin
            m_armed = 1'b1;
        end
        if (ctrl_w) n_ctrl = d[3:0];
        if (w && a == 2'd1) m_preset = d;
        m_ctrl = n_ctrl;
        m_pend = n_pend;
    endfunction

    function automatic void push_expect(input logic [1:0] a);
        logic [W-1:0] r;
        case (a)
            2'd0:    r = {{(W-4){1'b0}}, m_ctrl};
            2'd1:    r = m_preset;
            2'd2:    r = m_count;
            default: r = '0;
        endcase
        exp_q.push_back({m_pend & m_ctrl[3], r});
        adr_q.push_back(a);
    endfunction

    function automatic string reg_name(input logic [1:0] a);
        case (a)
            2'd0:    return "rd_ctrl";
            2'd1:    return "rd_preset";
            2'd2:    return "rd_count";
            default: return "rd_rsvd";
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic bus(input logic w, input logic [1:0] a, input logic [W-1:0] d);
        @(posedge clk);
        #1;
        we    = w;
        addr  = a;
        wdata = d;
        push_expect(a);
        model_edge(w, a, d);
    endtask

    task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
        bus(1'b1, a, d);
    endtask

    task automatic rd(input logic [1:0] a);
        bus(1'b0, a, W'($urandom));
    endtask

    task automatic rd_n(input logic [1:0] a, input int n);
        for (int i = 0; i < n; i++) rd(a);
    endtask

    // Reset asserted just after an edge; released between sampling and the next edge.
    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            we    = 1'b0;
            addr  = 2'(i % 4);
            wdata = W'($urandom);
            push_expect(addr);
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_edge(we, addr, wdata);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [W:0] exp_v;
        logic [W:0] got_v;
        logic [1:0] a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                a     = adr_q.pop_front();
                got_v = {irq, rdata};
                vectors++;
                if (got_v !== exp_v) begin
                    miscompares++;
                    $display("FAIL %s vec=%0d: irq=%b rdata=%h, expected irq=%b rdata=%h",
                             reg_name(a), vectors, got_v[W], got_v[W-1:0], exp_v[W], exp_v[W-1:0]);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete, %0d vectors pending", exp_q.size());
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        int sel;
        model_reset();

        // Reset values on every register, then again after release.
        do_reset(3);
        rd(2'd0); rd(2'd1); rd(2'd2); rd(2'd3);

        // One-shot: PRESET=3, EN|IM; irq latches until CTRL is rewritten.
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        rd_n(2'd2, 8);
        rd(2'd0);
        wr(2'd0, 32'h0);
        rd_n(2'd0, 2);

        // Auto-reload PRESET=2: one-cycle irq pulse every 4 cycles.
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        rd_n(2'd2, 16);
        wr(2'd0, 32'h0);

        // Masked one-shot: no irq, EN self-clears.
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h1);
        rd_n(2'd0, 9);
        rd(2'd2);

        // Disable mid-count: COUNT freezes.
        wr(2'd0, 32'h9);
        rd_n(2'd2, 3);
        wr(2'd0, 32'h0);
        rd_n(2'd2, 5);

        // PRESET rewritten mid-count only applies on the next reload.
        wr(2'd1, 32'd4);
        wr(2'd0, 32'hB);
        rd_n(2'd2, 3);
        wr(2'd1, 32'd10);
        rd_n(2'd2, 20);

        // Reset in the middle of a run.
        do_reset(2);
        rd(2'd0); rd(2'd1); rd(2'd2);

        // COUNT and reserved writes are ignored.
        wr(2'd1, 32'd7);
        wr(2'd2, 32'hFFFF);
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3); rd(2'd2); rd(2'd1);

        // PRESET=0 acts as PRESET=1 in auto-reload.
        wr(2'd1, 32'd0);
        wr(2'd0, 32'hB);
        rd_n(2'd2, 10);
        wr(2'd0, 32'h0);

        // CTRL upper bits read back as zero.
        wr(2'd0, 32'hFFFF_FFF0);
        rd(2'd0);
        wr(2'd0, 32'h0);

        // Random traffic with small presets so runs finish often.
        for (int i = 0; i < 700; i++) begin
            sel = $urandom_range(0, 11);
            if (sel < 8) begin
                rd(2'($urandom_range(0, 3)));
            end else if (sel == 8) begin
                wr(2'd0, W'($urandom));
            end else if (sel == 9) begin
                wr(2'd1, W'($urandom_range(0, 5)));
            end else if (sel == 10) begin
                wr(2'($urandom_range(2, 3)), W'($urandom));
            end else if ($urandom_range(0, 9) == 0) begin
                do_reset(1);
            end else begin
                rd(2'd2);
            end
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
